// File: rtl/uart_rx_fifo_gpio.sv
// uart_rx_fifo_gpio -- memory-mapped 8N1 UART receiver with a receive FIFO.
//
// Serial bytes from uart_rx are deserialised and queued so that firmware can
// fetch them later through two bus registers selected by addr[31:28]:
//   RXDATA   (SEL_RXDATA)   read pops the oldest byte, zero when empty
//   RXSTATUS (SEL_RXSTATUS) read  {19'h0, count[8:0], ferr, ovr, full, ~empty}
//                           write data_in[2] clears ovr, [3] clears ferr,
//                                 [4] flushes the FIFO
//
// Ports
//   clk        system clock, all logic on the rising edge
//   rst        synchronous reset, active-high
//   addr       CPU byte address, only addr[31:28] is decoded
//   data_in    CPU write data
//   rd_strobe  CPU read request
//   wr_strobe  CPU byte-write enables, any set bit counts as a write
//   data_out   registered read data, one clock of latency, holds when idle
//   uart_rx    asynchronous serial input, idle high
//   irq        high while the FIFO holds at least one byte
module uart_rx_fifo_gpio #(
  parameter int          CLK_FREQ     = 27000000,
  parameter int          BAUD         = 115200,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [3:0]  SEL_RXDATA   = 4'h5,
  parameter logic [3:0]  SEL_RXSTATUS = 4'h7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  input  logic        rd_strobe,
  input  logic [3:0]  wr_strobe,
  output logic [31:0] data_out,
  input  logic        uart_rx,
  output logic        irq
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW           = $clog2(FIFO_DEPTH);
  localparam int CW           = AW + 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CW-1:0]    DEPTH_C   = CW'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // ---- stage p0/p1: two-flop synchroniser, p2 keeps the previous sample for edge detect
  logic rx_p0, rx_p1, rx_prev_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_p0      <= 1'b1;
      rx_p1      <= 1'b1;
      rx_prev_p2 <= 1'b1;
    end else begin
      rx_p0      <= uart_rx;
      rx_p1      <= rx_p0;
      rx_prev_p2 <= rx_p1;
    end
  end

  logic rx_fall;
  assign rx_fall = ~rx_p1 & rx_prev_p2;

  // ---- frame FSM: start-bit qualification, data shift, stop-bit check
  logic [1:0]       state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       rx_shift;
  logic             push_req;
  logic             stop_bad;

  always_comb begin
    push_req = 1'b0;
    stop_bad = 1'b0;
    if (state == S_STOP && baud_cnt == BIT_LAST) begin
      push_req = rx_p1;
      stop_bad = ~rx_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // Only a real high-to-low transition starts a frame, so a line held
          // low after a break does not retrigger.
          if (rx_fall) begin
            state    <= S_START;
            baud_cnt <= '0;
          end
        end
        S_START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= rx_p1 ? S_IDLE : S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            state    <= S_IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_DATA && baud_cnt == BIT_LAST) rx_shift <= {rx_p1, rx_shift[7:1]};
  end

  // ---- bus decode and FIFO bookkeeping
  logic rd_data_sel, rd_stat_sel, wr_stat_sel;
  assign rd_data_sel = rd_strobe & (addr[31:28] == SEL_RXDATA);
  assign rd_stat_sel = rd_strobe & (addr[31:28] == SEL_RXSTATUS);
  assign wr_stat_sel = (|wr_strobe) & (addr[31:28] == SEL_RXSTATUS);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          empty, full, pop, push_ok, flush;
  logic          ovr, ferr;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign pop     = rd_data_sel & ~empty;
  // A pop in the same cycle frees the slot the incoming byte needs.
  assign push_ok = push_req & (~full | pop);
  assign flush   = wr_stat_sel & data_in[4];

  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else begin
      case ({push_ok, pop})
        2'b10:   count_nxt = count + 1'b1;
        2'b01:   count_nxt = count - 1'b1;
        default: count_nxt = count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      irq    <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_nxt;
      irq   <= (count_nxt != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= rx_shift;
  end

  // Sticky error flags: a new event in the same cycle wins over a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr  <= 1'b0;
      ferr <= 1'b0;
    end else begin
      if (push_req && !push_ok)         ovr <= 1'b1;
      else if (wr_stat_sel && data_in[2]) ovr <= 1'b0;
      if (stop_bad)                      ferr <= 1'b1;
      else if (wr_stat_sel && data_in[3]) ferr <= 1'b0;
    end
  end

  // ---- registered read mux
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
    end else if (rd_data_sel) begin
      data_out <= empty ? 32'h0 : {24'h0, mem[rd_ptr]};
    end else if (rd_stat_sel) begin
      data_out <= {19'h0, 9'(count), ferr, ovr, full, ~empty};
    end
  end

  logic unused_bits;
  assign unused_bits = ^{addr[27:0], data_in[31:5], data_in[1:0]};

endmodule

// File: tb/tb_uart_rx_fifo_gpio.sv
// Self-checking bench for uart_rx_fifo_gpio: scoreboard of expected read
// responses fed by the stimulus process and consumed by an independent
// monitor; the FIFO and flags are modelled with a byte queue and two bits.
module tb_uart_rx_fifo_gpio;

  localparam int         CLK_FREQ = 1000000;
  localparam int         BAUD     = 100000;
  localparam int         CPB      = CLK_FREQ / BAUD;
  localparam int         DEPTH    = 4;
  localparam logic [3:0] SEL_D    = 4'h5;
  localparam logic [3:0] SEL_S    = 4'h7;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic        rd_strobe;
  logic [3:0]  wr_strobe;
  logic [31:0] data_out;
  logic        uart_rx;
  logic        irq;

  uart_rx_fifo_gpio #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH),
    .SEL_RXDATA(SEL_D), .SEL_RXSTATUS(SEL_S)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in),
    .rd_strobe(rd_strobe), .wr_strobe(wr_strobe), .data_out(data_out),
    .uart_rx(uart_rx), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  logic [7:0] model_q[$];
  logic       m_ovr, m_ferr;

  // Scoreboard
  logic [31:0] exp_q[$];
  logic [31:0] mask_q[$];
  logic        irq_q[$];
  string       tag_q[$];
  logic [31:0] last_exp;
  int          vectors = 0;
  int          miscompares = 0;
  logic        probe = 1'b0;
  logic        due = 1'b0;

  function automatic logic [31:0] model_status();
    return {19'h0, 9'(model_q.size()), m_ferr, m_ovr,
            (model_q.size() == DEPTH), (model_q.size() != 0)};
  endfunction

  task automatic expect_rsp(input logic [31:0] e, input logic [31:0] m, input string tag);
    exp_q.push_back(e);
    mask_q.push_back(m);
    irq_q.push_back(model_q.size() != 0);
    tag_q.push_back(tag);
    if (m == 32'hFFFF_FFFF) last_exp = e;
  endtask

  // Monitor: a response is due one clock after a selected read or a probe.
  initial forever begin
    @(posedge clk);
    due = (rd_strobe && (addr[31:28] == SEL_D || addr[31:28] == SEL_S)) || probe;
  end

  initial forever begin
    @(negedge clk);
    if (due) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_response data_out=%h irq=%b", data_out, irq);
      end else begin
        logic [31:0] e, m;
        logic        ei;
        string       t;
        e  = exp_q.pop_front();
        m  = mask_q.pop_front();
        ei = irq_q.pop_front();
        t  = tag_q.pop_front();
        vectors++;
        if ((data_out & m) !== (e & m)) begin
          miscompares++;
          $display("FAIL %s data_out got=%h want=%h (mask %h)", t, data_out, e, m);
        end
        vectors++;
        if (irq !== ei) begin
          miscompares++;
          $display("FAIL %s_irq got=%b want=%b", t, irq, ei);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_data(input string tag);
    logic [31:0] e;
    addr      = {SEL_D, 28'($urandom)};
    rd_strobe = 1'b1;
    e = (model_q.size() == 0) ? 32'h0 : {24'h0, model_q.pop_front()};
    expect_rsp(e, 32'hFFFF_FFFF, tag);
    tick();
    rd_strobe = 1'b0;
  endtask

  task automatic rd_status(input string tag);
    addr      = {SEL_S, 28'($urandom)};
    rd_strobe = 1'b1;
    expect_rsp(model_status(), 32'hFFFF_FFFF, tag);
    tick();
    rd_strobe = 1'b0;
  endtask

  task automatic rd_other();
    addr      = {4'h3, 28'($urandom)};
    rd_strobe = 1'b1;
    probe     = 1'b1;
    expect_rsp(last_exp, 32'hFFFF_FFFF, "hold_unselected");
    tick();
    rd_strobe = 1'b0;
    probe     = 1'b0;
  endtask

  task automatic wr_reg(input logic [3:0] sel, input logic [31:0] d);
    addr      = {sel, 28'($urandom)};
    data_in   = d;
    wr_strobe = 4'($urandom_range(1, 15));
    if (sel == SEL_S) begin
      if (d[2]) m_ovr = 1'b0;
      if (d[3]) m_ferr = 1'b0;
      if (d[4]) model_q.delete();
    end
    tick();
    wr_strobe = 4'h0;
  endtask

  // Drives one 8N1 frame. rd_at >= 0 pops RXDATA in that bit-clock slot;
  // poll reads RXSTATUS every slot and reports the first slot showing ovr.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int extra_low,
                            input int rd_at, input bit poll, output int seen);
    seen = -1;
    for (int i = 0; i < 10 * CPB; i++) begin
      int k;
      k = i / CPB;
      uart_rx   = (k == 0) ? 1'b0 : (k <= 8) ? b[3'(k - 1)] : stop_ok;
      rd_strobe = 1'b0;
      if (poll) begin
        addr      = {SEL_S, 28'h0};
        rd_strobe = 1'b1;
        expect_rsp(model_status(), ~32'h4, "calib_poll");
      end
      if (i == rd_at) begin
        addr      = {SEL_D, 28'h0};
        rd_strobe = 1'b1;
        expect_rsp((model_q.size() == 0) ? 32'h0 : {24'h0, model_q.pop_front()},
                   32'hFFFF_FFFF, "pop_on_push");
      end
      tick();
      if (poll && seen < 0 && data_out[2]) seen = i;
    end
    rd_strobe = 1'b0;
    if (extra_low > 0) repeat (extra_low) tick();
    uart_rx = 1'b1;
    repeat (4) tick();
    if (!stop_ok) m_ferr = 1'b1;
    else if (model_q.size() < DEPTH) model_q.push_back(b);
    else m_ovr = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    int s;
    send_frame(b, 1'b1, 0, -1, 1'b0, s);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    probe = 1'b1;
    model_q.delete();
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    expect_rsp(32'h0, 32'hFFFF_FFFF, "reset_state");
    tick();
    rst   = 1'b0;
    probe = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    int seen, rd_at;
    rst = 1'b1; addr = '0; data_in = '0; rd_strobe = 1'b0; wr_strobe = '0;
    uart_rx = 1'b1; last_exp = '0; m_ovr = 1'b0; m_ferr = 1'b0;
    repeat (3) tick();
    do_reset();
    tick();
    rd_status("reset_status");

    // Single byte
    send(8'hA5);
    rd_status("t1_status");
    rd_data("t1_data");
    rd_status("t1_status_empty");

    // Overflow and ordering
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
    rd_status("t2_status_full");
    for (int i = 0; i < 4; i++) rd_data("t2_data");
    rd_data("t2_data_empty");
    wr_reg(SEL_S, 32'h4);
    rd_status("t2_ovr_clear");

    // Framing error followed by a break
    send_frame(8'h3C, 1'b0, 30, -1, 1'b0, seen);
    rd_status("t3_ferr");
    wr_reg(SEL_S, 32'h8);
    rd_status("t3_ferr_clear");

    // Short glitch on idle line
    uart_rx = 1'b0;
    repeat (3) tick();
    uart_rx = 1'b1;
    repeat (20) tick();
    rd_status("t4_glitch");

    // Locate the stop-sample slot on a full FIFO, then pop exactly there
    for (int i = 0; i < DEPTH; i++) send(8'($urandom));
    rd_status("t5_full");
    send_frame(8'($urandom), 1'b1, 0, -1, 1'b1, seen);
    rd_status("t5_ovr_set");
    wr_reg(SEL_S, 32'h4);
    vectors++;
    if (seen < 1) begin
      miscompares++;
      $display("FAIL t5_calibration got=%0d want=positive slot", seen);
      rd_at = 10 * CPB - 3;
    end else begin
      rd_at = seen - 1;
    end
    send_frame(8'h66, 1'b1, 0, rd_at, 1'b0, seen);
    rd_status("t5_status_after");
    for (int i = 0; i < DEPTH; i++) rd_data("t5_drain");

    // Flush and ignored RXDATA write
    send(8'h81); send(8'h82);
    wr_reg(SEL_D, 32'h1C);
    rd_status("rxdata_write_ignored");
    wr_reg(SEL_S, 32'h10);
    rd_status("flush_status");
    rd_data("flush_data");

    // Reset during bit 4 of a frame
    send(8'h77);
    send_frame(8'h12, 1'b0, 0, -1, 1'b0, seen);
    rd_status("t6_before");
    uart_rx = 1'b0;
    repeat (CPB) tick();
    for (int k = 0; k < 4; k++) begin
      uart_rx = 1'b1 ^ k[0];
      repeat (CPB) tick();
    end
    uart_rx = 1'b1;
    repeat (CPB / 2) tick();
    do_reset();
    uart_rx = 1'b1;
    repeat (120) tick();
    rd_status("t6_after_reset");
    send(8'h5A);
    rd_status("t6_status");
    rd_data("t6_data");

    // Randomised mix
    for (int n = 0; n < 40; n++) begin
      int act;
      act = $urandom_range(0, 9);
      if (act <= 3) begin
        send_frame(8'($urandom), ($urandom_range(0, 7) != 0), 0, -1, 1'b0, seen);
      end else if (act <= 5) begin
        rd_data("rand_data");
      end else if (act == 6) begin
        rd_status("rand_status");
      end else if (act == 7) begin
        logic [31:0] d;
        d = $urandom;
        if ($urandom_range(0, 3) != 0) d[4] = 1'b0;
        wr_reg(SEL_S, d);
      end else if (act == 8) begin
        wr_reg(SEL_D, $urandom);
        rd_other();
      end else begin
        repeat ($urandom_range(1, 15)) tick();
      end
    end
    rd_status("final_status");
    for (int i = 0; i < DEPTH + 1; i++) rd_data("final_drain");
    rd_status("final_empty");

    repeat (3) tick();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
